// File: rtl/neuron_accumulator_if.sv
// Handshake bundle between the neuron datapath (master) and neuron_accumulator (slave).
interface neuron_accumulator_if #(
    parameter int num_width = 8,
    parameter int acc_width = 24
);
    logic                   start;
    logic [acc_width-1:0]   bias_in;
    logic                   prod_valid;
    logic [2*num_width-1:0] prod_in;
    logic                   prod_ready;
    logic [acc_width-1:0]   acc_out;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   overflow;

    modport master (
        output start, bias_in, prod_valid, prod_in, out_ready,
        input  prod_ready, acc_out, out_valid, busy, overflow
    );

    modport slave (
        input  start, bias_in, prod_valid, prod_in, out_ready,
        output prod_ready, acc_out, out_valid, busy, overflow
    );
endinterface

// File: rtl/neuron_accumulator.sv
// Sums num_inputs unsigned products on top of a bias, one neuron per start pulse.
// Define ACC_SATURATE_EN to clamp on carry out and flag overflow; otherwise the sum wraps.
module neuron_accumulator #(
    parameter int num_width  = 8,
    parameter int num_inputs = 16,
    parameter int acc_width  = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    neuron_accumulator_if.slave  bus
);
    localparam int CW = $clog2(num_inputs + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state_q;
    logic [acc_width-1:0] acc_q, acc_d, acc_out_q;
    logic [CW-1:0]        count_q;
    logic                 prod_ready_q, out_valid_q, busy_q, overflow_q, overflow_d;
    logic                 beat, last;

    assign beat = bus.prod_valid & prod_ready_q;
    assign last = (count_q == CW'(num_inputs - 1));

`ifdef ACC_SATURATE_EN
    logic [acc_width:0] sum;
    assign sum        = {1'b0, acc_q} + (acc_width+1)'(bus.prod_in);
    // Once clamped, stay clamped for the rest of this accumulation.
    assign overflow_d = overflow_q | sum[acc_width];
    assign acc_d      = overflow_d ? '1 : sum[acc_width-1:0];
`else
    assign acc_d      = acc_q + acc_width'(bus.prod_in);
    assign overflow_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            acc_out_q    <= '0;
            count_q      <= '0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    acc_q        <= bus.bias_in;
                    count_q      <= '0;
                    overflow_q   <= 1'b0;
                    prod_ready_q <= 1'b1;
                    busy_q       <= 1'b1;
                    state_q      <= ACCUM;
                end
                ACCUM: if (beat) begin
                    acc_q      <= acc_d;
                    count_q    <= count_q + CW'(1);
                    overflow_q <= overflow_d;
                    if (last) begin
                        acc_out_q    <= acc_d;
                        prod_ready_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                // start is deliberately ignored here; a restart needs an IDLE cycle.
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.acc_out    = acc_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_neuron_accumulator.sv
module tb_neuron_accumulator;
  localparam int     NW   = 8;
  localparam int     NI   = 4;
  localparam int     AW   = 20;
  localparam longint AMAX = (64'd1 << AW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  neuron_accumulator_if #(.num_width(NW), .acc_width(AW)) bus ();

  neuron_accumulator #(.num_width(NW), .num_inputs(NI), .acc_width(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic void model(input longint bias, input longint p[NI],
                                output longint sum, output logic ov);
    sum = bias;
    ov  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      sum += p[i];
`ifdef ACC_SATURATE_EN
      if (sum > AMAX) begin sum = AMAX; ov = 1'b1; end
`else
      sum = sum % (AMAX + 1);
`endif
    end
  endfunction

  task automatic run(input longint bias, input longint p[NI], input int gaps[NI], output int cyc);
    cyc = 0;
    bus.start = 1'b1; bus.bias_in = AW'(bias);
    step(); cyc++;
    bus.start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      repeat (gaps[i]) begin step(); cyc++; end
      chk("prod_ready_accum", bus.prod_ready === 1'b1);
      bus.prod_valid = 1'b1; bus.prod_in = 16'(p[i]);
      step(); cyc++;
      bus.prod_valid = 1'b0;
    end
    for (int k = 0; k < 20 && bus.out_valid !== 1'b1; k++) begin step(); cyc++; end
    chk("out_valid_done", bus.out_valid === 1'b1);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("out_valid_after_take", bus.out_valid === 1'b0);
    chk("busy_after_take", bus.busy === 1'b0);
  endtask

  initial begin
    longint p[NI];
    int     g[NI];
    int     cyc;
    longint exp_sum;
    logic   exp_ov;

    bus.start = 1'b0; bus.bias_in = '0; bus.prod_valid = 1'b0;
    bus.prod_in = '0; bus.out_ready = 1'b0;

    #3;
    chk("rst_acc_out", bus.acc_out === 20'd0);
    chk("rst_out_valid", bus.out_valid === 1'b0);
    chk("rst_prod_ready", bus.prod_ready === 1'b0);
    chk("rst_busy", bus.busy === 1'b0);
    chk("rst_overflow", bus.overflow === 1'b0);
    #9 reset = 1'b1;
    step();

    p = '{100, 200, 300, 400}; g = '{0, 0, 0, 0};
    run(10, p, g, cyc);
    chk("t1_latency", cyc === 5);
    chk("t1_acc_out", bus.acc_out === 20'd1010);
    chk("t1_overflow", bus.overflow === 1'b0);
    chk("t1_busy", bus.busy === 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_hold_valid", bus.out_valid === 1'b1);
      chk("t3_hold_acc", bus.acc_out === 20'd1010);
      chk("t3_hold_ready", bus.prod_ready === 1'b0);
    end
    release_out();
    chk("t3_acc_kept_idle", bus.acc_out === 20'd1010);

    g = '{1, 3, 2, 2};
    run(10, p, g, cyc);
    chk("t2_latency", cyc === 1 + 8 + NI);
    chk("t2_acc_out", bus.acc_out === 20'd1010);
    release_out();

    p = '{65025, 65025, 65025, 65025}; g = '{0, 0, 0, 0};
    run(1048000, p, g, cyc);
`ifdef ACC_SATURATE_EN
    chk("t4_acc_out", bus.acc_out === 20'd1048575);
    chk("t4_overflow", bus.overflow === 1'b1);
`else
    chk("t4_acc_out", bus.acc_out === 20'd259524);
    chk("t4_overflow", bus.overflow === 1'b0);
`endif
    release_out();

    bus.start = 1'b1; bus.bias_in = 20'd999; step(); bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.prod_valid = 1'b1; bus.prod_in = 16'd5000; step();
    end
    bus.prod_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t5_acc_out", bus.acc_out === 20'd0);
    chk("t5_out_valid", bus.out_valid === 1'b0);
    chk("t5_prod_ready", bus.prod_ready === 1'b0);
    chk("t5_busy", bus.busy === 1'b0);
    chk("t5_overflow", bus.overflow === 1'b0);
    #3 reset = 1'b1;
    step();
    p = '{100, 200, 300, 400};
    run(7, p, g, cyc);
    chk("t5_fresh_sum", bus.acc_out === 20'd1007);
    release_out();

    run(10, p, g, cyc);
    bus.start = 1'b1; bus.bias_in = 20'd5; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t6_no_restart_busy", bus.busy === 1'b0);
    chk("t6_no_restart_ready", bus.prod_ready === 1'b0);
    bus.bias_in = 20'd20;
    step();
    bus.start = 1'b0;
    chk("t6_restart_busy", bus.busy === 1'b1);
    chk("t6_restart_ready", bus.prod_ready === 1'b1);
    for (int i = 0; i < NI; i++) begin
      bus.prod_valid = 1'b1; bus.prod_in = 16'(i + 1); step();
    end
    bus.prod_valid = 1'b0;
    chk("t6_valid", bus.out_valid === 1'b1);
    chk("t6_acc_out", bus.acc_out === 20'd30);
    release_out();

    for (int r = 0; r < 10; r++) begin
      longint bias;
      bias = longint'($urandom_range(0, 32'(AMAX)));
      for (int i = 0; i < NI; i++) begin
        p[i] = longint'($urandom_range(0, 65025));
        g[i] = int'($urandom_range(0, 3));
      end
      model(bias, p, exp_sum, exp_ov);
      run(bias, p, g, cyc);
      chk("rnd_acc_out", bus.acc_out === AW'(exp_sum));
      chk("rnd_overflow", bus.overflow === exp_ov);
      release_out();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
